// File: rtl/music_pkg.sv
// Shared types and default constants for the tone sequencer.
// note_t fixes the stored field widths, so DIV_W/DUR_W must not exceed DefDivW/DefDurW.
package music_pkg;

  localparam int unsigned DefClkFreq = 1000000;
  localparam int unsigned DefBeatHz  = 8;
  localparam int unsigned DefDepth   = 32;
  localparam int unsigned DefDivW    = 16;
  localparam int unsigned DefDurW    = 4;

  typedef enum logic [1:0] {
    StIdle,
    StPlay,
    StPause
  } state_e;

  // One melody slot: half-period divider (0 = rest) and duration in beats minus 1.
  typedef struct packed {
    logic [DefDivW-1:0] div;
    logic [DefDurW-1:0] dur;
  } note_t;

endpackage

// File: rtl/tone_sequencer_if.sv
// Note-write, control and status bundle for the tone sequencer.
interface tone_sequencer_if
  import music_pkg::*;
#(
  parameter int unsigned AW    = $clog2(DefDepth),
  parameter int unsigned DIV_W = DefDivW,
  parameter int unsigned DUR_W = DefDurW
);
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DIV_W-1:0] wr_div;
  logic [DUR_W-1:0] wr_dur;
  logic [AW:0]      len;
  logic             start;
  logic             control;
  logic             loop;
  logic             buzz;
  logic             playing;
  logic             complete;
  logic [AW-1:0]    note_idx;

  modport master (
    output wr_en, wr_addr, wr_div, wr_dur, len, start, control, loop,
    input  buzz, playing, complete, note_idx
  );

  modport slave (
    input  wr_en, wr_addr, wr_div, wr_dur, len, start, control, loop,
    output buzz, playing, complete, note_idx
  );
endinterface

// File: rtl/beat_tick_gen.sv
// Beat tick generator: free-running phase counter that pulses tick_o every BEAT_CYC
// enabled cycles. clr_i restarts the beat and wins over en_i.
module beat_tick_gen #(
  parameter int unsigned BEAT_CYC = 16,
  localparam int unsigned PW = (BEAT_CYC > 1) ? $clog2(BEAT_CYC) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en_i,
  input  logic          clr_i,
  output logic          tick_o,
  output logic [PW-1:0] phase_o
);
  logic [PW-1:0] cnt_q, cnt_d;

  assign tick_o  = en_i && !clr_i && (cnt_q == PW'(BEAT_CYC - 1));
  assign phase_o = cnt_q;

  // Next phase: clear, wrap on tick, otherwise count while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + PW'(1);
    end
  end

  // Phase register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/tone_sequencer.sv
// Tone sequencer: plays a melody of {div, dur} notes from a small slot memory as a
// square wave on buzz, with pause, loop and restart.
// Optional feature macro: TONE_SEQ_STACCATO_EN mutes the last quarter of each note's
// final beat.
module tone_sequencer
  import music_pkg::*;
#(
  parameter int unsigned CLK_FREQ = DefClkFreq,
  parameter int unsigned BEAT_HZ  = DefBeatHz,
  parameter int unsigned DEPTH    = DefDepth,
  parameter int unsigned DIV_W    = DefDivW,
  parameter int unsigned DUR_W    = DefDurW
) (
  input logic            clk,
  input logic            reset,
  tone_sequencer_if.slave bus
);
  localparam int unsigned BEAT_CYC = CLK_FREQ / BEAT_HZ;
  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned PW       = (BEAT_CYC > 1) ? $clog2(BEAT_CYC) : 1;

  note_t            mem_q [DEPTH];
  state_e           state_q, state_d;
  logic [AW:0]      len_q, len_d;
  logic [AW-1:0]    idx_q, idx_d, idx_nxt;
  note_t            cur_q, cur_d;
  logic [DIV_W-1:0] tone_q, tone_d;
  logic [DUR_W-1:0] beat_q, beat_d;
  logic             buzz_q, buzz_d;
  logic             complete_q, complete_d;

  logic             restart, run, tick, note_end, last, mute;
  logic [PW-1:0]    phase;

  assign restart  = bus.start && (bus.len != '0);
  // Counters advance only while playing with pause released; this makes a pause of
  // N cycles stretch the note by exactly N cycles.
  assign run      = (state_q != StIdle) && !bus.control;
  assign note_end = tick && (beat_q == DUR_W'(cur_q.dur));
  assign last     = (({1'b0, idx_q} + (AW + 1)'(1)) == len_q);
  assign idx_nxt  = last ? '0 : idx_q + AW'(1);

  beat_tick_gen #(
    .BEAT_CYC (BEAT_CYC)
  ) u_beat (
    .clk     (clk),
    .reset   (reset),
    .en_i    (run),
    .clr_i   (restart),
    .tick_o  (tick),
    .phase_o (phase)
  );

`ifdef TONE_SEQ_STACCATO_EN
  localparam int unsigned StacStart = BEAT_CYC - BEAT_CYC / 4;
  assign mute = (beat_q == DUR_W'(cur_q.dur)) && (32'(phase) >= StacStart);
`else
  logic unused_phase;
  assign unused_phase = ^phase;
  assign mute         = 1'b0;
`endif

  assign bus.buzz     = buzz_q && (state_q == StPlay) && !mute;
  assign bus.playing  = (state_q != StIdle);
  assign bus.complete = complete_q;
  assign bus.note_idx = idx_q;

  // Slot memory: written whenever wr_en is high, never reset.
  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      mem_q[bus.wr_addr] <= '{div: DefDivW'(bus.wr_div), dur: DefDurW'(bus.wr_dur)};
    end
  end

  // Next-state: restart beats everything, then note sequencing, then pause tracking.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    cur_d      = cur_q;
    tone_d     = tone_q;
    beat_d     = beat_q;
    buzz_d     = buzz_q;
    complete_d = 1'b0;
    if (restart) begin
      state_d = StPlay;
      len_d   = bus.len;
      idx_d   = '0;
      cur_d   = mem_q[0];
      tone_d  = '0;
      beat_d  = '0;
      buzz_d  = 1'b0;
    end else if (run) begin
      state_d = StPlay;
      if (note_end) begin
        tone_d = '0;
        beat_d = '0;
        buzz_d = 1'b0;
        if (!last || bus.loop) begin
          idx_d = idx_nxt;
          cur_d = mem_q[idx_nxt];
        end else begin
          state_d    = StIdle;
          complete_d = 1'b1;
        end
      end else begin
        if (tick) begin
          beat_d = beat_q + DUR_W'(1);
        end
        if (cur_q.div == '0) begin
          tone_d = '0;
          buzz_d = 1'b0;
        end else if (tone_q == DIV_W'(cur_q.div) - DIV_W'(1)) begin
          tone_d = '0;
          buzz_d = !buzz_q;
        end else begin
          tone_d = tone_q + DIV_W'(1);
        end
      end
    end else if (state_q != StIdle) begin
      state_d = StPause;
    end
  end

  // Sequencer state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      len_q      <= '0;
      idx_q      <= '0;
      cur_q      <= '0;
      tone_q     <= '0;
      beat_q     <= '0;
      buzz_q     <= 1'b0;
      complete_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      cur_q      <= cur_d;
      tone_q     <= tone_d;
      beat_q     <= beat_d;
      buzz_q     <= buzz_d;
      complete_q <= complete_d;
    end
  end
endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer at CLK_FREQ=64, BEAT_HZ=4 (16-cycle beat), DEPTH=8.
module tb_tone_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   vectors     = 0;
  int   miscompares = 0;

  tone_sequencer_if #(.AW(3), .DIV_W(16), .DUR_W(4)) bus ();

  tone_sequencer #(
    .CLK_FREQ (64),
    .BEAT_HZ  (4),
    .DEPTH    (8),
    .DIV_W    (16),
    .DUR_W    (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_slot(input int a, input int div, input int dur);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 3'(a);
    bus.wr_div  = 16'(div);
    bus.wr_dur  = 4'(dur);
    cyc(1);
    bus.wr_en   = 1'b0;
  endtask

  task automatic start_play(input int l, input logic lp);
    bus.len   = 4'(l);
    bus.loop  = lp;
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
  endtask

  // Expected buzz k run-cycles into a div=2, dur=1 note.
  function automatic logic exp_div2(input int k);
    logic b;
    b = 1'((k >> 1) & 1);
`ifdef TONE_SEQ_STACCATO_EN
    if (k >= 28) b = 1'b0;
`endif
    return b;
  endfunction

  initial begin
    reset       = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_div  = '0;
    bus.wr_dur  = '0;
    bus.len     = '0;
    bus.start   = 1'b0;
    bus.control = 1'b0;
    bus.loop    = 1'b0;
    cyc(2);
    reset = 1'b1;
    check("rst_playing", bus.playing, 0);
    check("rst_buzz", bus.buzz, 0);
    check("rst_complete", bus.complete, 0);
    check("rst_idx", bus.note_idx, 0);

    // Melody: slot0 {div=2, dur=1}, slot1 rest {div=0, dur=0}.
    write_slot(0, 2, 1);
    write_slot(1, 0, 0);

    // Single pass, no loop.
    start_play(2, 1'b0);
    check("p1_playing", bus.playing, 1);
    check("p1_idx", bus.note_idx, 0);
    check("p1_buzz", bus.buzz, 0);
    for (int k = 1; k <= 49; k++) begin
      cyc(1);
      if (k < 32) begin
        check($sformatf("p1_n0_buzz@%0d", k), bus.buzz, 32'(exp_div2(k)));
        check($sformatf("p1_n0_idx@%0d", k), bus.note_idx, 0);
      end else if (k < 48) begin
        check($sformatf("p1_n1_buzz@%0d", k), bus.buzz, 0);
        check($sformatf("p1_n1_idx@%0d", k), bus.note_idx, 1);
        check($sformatf("p1_n1_play@%0d", k), bus.playing, 1);
      end else begin
        check($sformatf("p1_end_play@%0d", k), bus.playing, 0);
      end
      check($sformatf("p1_complete@%0d", k), bus.complete, 32'(k == 48));
    end

    // Pause for 10 cycles inside note0: note stretches from 32 to 42 cycles.
    start_play(2, 1'b0);
    cyc(3);
    check("pz_pre_buzz", bus.buzz, 1);
    bus.control = 1'b1;
    for (int k = 4; k <= 13; k++) begin
      cyc(1);
      check($sformatf("pz_buzz@%0d", k), bus.buzz, 0);
      check($sformatf("pz_play@%0d", k), bus.playing, 1);
      check($sformatf("pz_idx@%0d", k), bus.note_idx, 0);
    end
    bus.control = 1'b0;
    for (int k = 14; k <= 45; k++) begin
      cyc(1);
      if (k < 42) begin
        check($sformatf("pz_run_buzz@%0d", k), bus.buzz, 32'(exp_div2(k - 10)));
        check($sformatf("pz_run_idx@%0d", k), bus.note_idx, 0);
      end else begin
        check($sformatf("pz_n1_idx@%0d", k), bus.note_idx, 1);
      end
    end

    // Reset mid-play aborts with no complete pulse.
    reset = 1'b0;
    cyc(1);
    check("abort_play", bus.playing, 0);
    check("abort_complete", bus.complete, 0);
    check("abort_idx", bus.note_idx, 0);
    check("abort_buzz", bus.buzz, 0);
    reset = 1'b1;
    cyc(1);
    check("abort_complete2", bus.complete, 0);
    check("abort_play2", bus.playing, 0);

    // Start with len=0 is ignored.
    start_play(0, 1'b0);
    check("len0_play", bus.playing, 0);
    check("len0_complete", bus.complete, 0);
    cyc(1);
    check("len0_complete2", bus.complete, 0);
    check("len0_play2", bus.playing, 0);

    // Loop; rewrite slot0 to div=3 while it plays; restart mid-note.
    start_play(2, 1'b1);
    for (int k = 1; k <= 52; k++) begin
      if (k == 5) begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'd0;
        bus.wr_div  = 16'd3;
        bus.wr_dur  = 4'd1;
      end
      cyc(1);
      bus.wr_en = 1'b0;
      check($sformatf("lp_complete@%0d", k), bus.complete, 0);
      if (k < 32) begin
        check($sformatf("lp_idx@%0d", k), bus.note_idx, 0);
        check($sformatf("lp_old_div_buzz@%0d", k), bus.buzz, 32'(exp_div2(k)));
      end else if (k < 48) begin
        check($sformatf("lp_idx@%0d", k), bus.note_idx, 1);
        check($sformatf("lp_rest_buzz@%0d", k), bus.buzz, 0);
      end else begin
        check($sformatf("lp_idx@%0d", k), bus.note_idx, 0);
        check($sformatf("lp_new_div_buzz@%0d", k), bus.buzz, 32'(((k - 48) / 3) & 1));
      end
    end
    start_play(2, 1'b1);
    check("rs_idx", bus.note_idx, 0);
    check("rs_buzz", bus.buzz, 0);
    check("rs_play", bus.playing, 1);
    check("rs_complete", bus.complete, 0);
    cyc(2);
    check("rs_buzz2", bus.buzz, 0);
    cyc(1);
    check("rs_buzz3", bus.buzz, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
